// File: rtl/reg_file.sv
// Integer register file: 32 x XLEN, two combinational read ports with write-through
// bypass, one synchronous write port, and a load-busy scoreboard for load-use stalls.
module reg_file #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            reg_wr,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            issue_load,
  input  logic [4:0]      issue_rd,
  input  logic            kill_load,
  input  logic [4:0]      kill_rd,
  output logic            load_use_stall
);

  localparam int unsigned AW = 5;

  // x0 is not stored; index 0 of the array does not exist.
  logic [XLEN-1:0]  regs_q [1:NREGS-1];
  logic [NREGS-1:1] busy_q, busy_d;
  logic [NREGS-1:0] busy_vec;

  logic             wr_en;
  logic             byp1, byp2;
  logic             hit1, hit2;

  assign wr_en    = reg_wr && (waddr != '0);
  assign busy_vec = {busy_q, 1'b0};

  // Bypass only matters for non-zero addresses, which wr_en already guarantees.
  assign byp1 = wr_en && (waddr == raddr1);
  assign byp2 = wr_en && (waddr == raddr2);

  // Read port 1
  always_comb begin
    rdata1 = '0;
    if (raddr1 != '0) begin
      if (byp1) begin
        rdata1 = wdata;
      end else begin
        rdata1 = regs_q[raddr1];
      end
    end
  end

  // Read port 2
  always_comb begin
    rdata2 = '0;
    if (raddr2 != '0) begin
      if (byp2) begin
        rdata2 = wdata;
      end else begin
        rdata2 = regs_q[raddr2];
      end
    end
  end

  // Write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 1; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Scoreboard next state: a new issue is younger than any writeback or kill.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 1; r < NREGS; r++) begin
      if (issue_load && (issue_rd == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (reg_wr && (waddr == AW'(r))) begin
        busy_d[r] = 1'b0;
      end else if (kill_load && (kill_rd == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A register being written this cycle is served by the bypass, so it does not stall.
  assign hit1 = busy_vec[raddr1] && !(reg_wr && (waddr == raddr1));
  assign hit2 = busy_vec[raddr2] && !(reg_wr && (waddr == raddr2));

  assign load_use_stall = hit1 || hit2;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, x0, bypass, load-use stall, kill and collision cases.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        reg_wr;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        issue_load;
  logic [4:0]  issue_rd;
  logic        kill_load;
  logic [4:0]  kill_rd;
  logic        load_use_stall;

  int n_cmp = 0;
  int n_err = 0;

  reg_file #(
    .XLEN (32),
    .NREGS(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .raddr1        (raddr1),
    .raddr2        (raddr2),
    .rdata1        (rdata1),
    .rdata2        (rdata2),
    .reg_wr        (reg_wr),
    .waddr         (waddr),
    .wdata         (wdata),
    .issue_load    (issue_load),
    .issue_rd      (issue_rd),
    .kill_load     (kill_load),
    .kill_rd       (kill_rd),
    .load_use_stall(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed well away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; raddr1 = '0; raddr2 = '0; reg_wr = 1'b0; waddr = '0; wdata = '0;
    issue_load = 1'b0; issue_rd = '0; kill_load = 1'b0; kill_rd = '0;
    #2;
    raddr1 = 5'd5;
    #1;
    check("reset_rdata1", rdata1, 32'h0);
    check("reset_stall", {31'b0, load_use_stall}, 32'h0);
    tick();
    rst = 1'b0;

    // Write x5 and issue a load to x6, then reset between edges.
    reg_wr = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    issue_load = 1'b1; issue_rd = 5'd6;
    tick();
    reg_wr = 1'b0; issue_load = 1'b0; raddr1 = 5'd5; raddr2 = 5'd6;
    #1;
    check("x5_written", rdata1, 32'hDEADBEEF);
    check("x6_busy_stall", {31'b0, load_use_stall}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rdata1", rdata1, 32'h0);
    check("async_rst_stall", {31'b0, load_use_stall}, 32'h0);
    // Edges during reset leave state alone, but the bypass still passes wdata.
    reg_wr = 1'b1; waddr = 5'd5; wdata = 32'h00000055;
    #1;
    check("rst_bypass", rdata1, 32'h00000055);
    tick();
    reg_wr = 1'b0;
    #1;
    check("rst_edge_no_write", rdata1, 32'h0);
    rst = 1'b0;

    // x0 is hardwired to zero, no bypass.
    reg_wr = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    check("x0_no_bypass", rdata1, 32'h0);
    tick();
    reg_wr = 1'b0;
    #1;
    check("x0_rdata1", rdata1, 32'h0);
    check("x0_rdata2", rdata2, 32'h0);
    check("x0_stall", {31'b0, load_use_stall}, 32'h0);

    // Issue to x0 must not create a busy bit.
    issue_load = 1'b1; issue_rd = 5'd0;
    tick();
    issue_load = 1'b0;
    #1;
    check("x0_issue_no_stall", {31'b0, load_use_stall}, 32'h0);

    // Write/read with bypass on x7.
    reg_wr = 1'b1; waddr = 5'd7; wdata = 32'h12345678; raddr2 = 5'd7; raddr1 = 5'd7;
    #1;
    check("bypass_rdata2", rdata2, 32'h12345678);
    check("bypass_rdata1", rdata1, 32'h12345678);
    tick();
    reg_wr = 1'b0;
    #1;
    check("array_rdata2", rdata2, 32'h12345678);

    // Load-use stall on x3.
    issue_load = 1'b1; issue_rd = 5'd3; raddr1 = 5'd3; raddr2 = 5'd0;
    #1;
    check("busy_not_yet", {31'b0, load_use_stall}, 32'h0);
    tick();
    issue_load = 1'b0;
    #1;
    check("stall_port1", {31'b0, load_use_stall}, 32'h1);
    raddr1 = 5'd0; raddr2 = 5'd3;
    #1;
    check("stall_port2", {31'b0, load_use_stall}, 32'h1);
    tick();
    raddr1 = 5'd3; raddr2 = 5'd0;
    reg_wr = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
    #1;
    check("wb_no_stall", {31'b0, load_use_stall}, 32'h0);
    check("wb_bypass", rdata1, 32'hA5A5A5A5);
    tick();
    reg_wr = 1'b0;
    #1;
    check("wb_busy_clear", {31'b0, load_use_stall}, 32'h0);
    check("wb_array", rdata1, 32'hA5A5A5A5);

    // Kill of an in-flight load to x9.
    reg_wr = 1'b1; waddr = 5'd9; wdata = 32'hCAFEF00D;
    tick();
    reg_wr = 1'b0; issue_load = 1'b1; issue_rd = 5'd9;
    tick();
    issue_load = 1'b0; kill_load = 1'b1; kill_rd = 5'd9; raddr2 = 5'd9; raddr1 = 5'd0;
    #1;
    check("kill_cycle_stall", {31'b0, load_use_stall}, 32'h1);
    tick();
    kill_load = 1'b0;
    #1;
    check("kill_no_stall", {31'b0, load_use_stall}, 32'h0);
    check("kill_data_kept", rdata2, 32'hCAFEF00D);

    // Collision: issue and writeback to x4 in one cycle.
    issue_load = 1'b1; issue_rd = 5'd4; reg_wr = 1'b1; waddr = 5'd4; wdata = 32'h00000011;
    raddr1 = 5'd4; raddr2 = 5'd0;
    tick();
    issue_load = 1'b0; reg_wr = 1'b0;
    #1;
    check("coll_array", rdata1, 32'h00000011);
    check("coll_busy", {31'b0, load_use_stall}, 32'h1);

    // Issue and kill together: set wins.
    issue_load = 1'b1; issue_rd = 5'd4; kill_load = 1'b1; kill_rd = 5'd4;
    tick();
    issue_load = 1'b0; kill_load = 1'b0;
    #1;
    check("issue_kill_set", {31'b0, load_use_stall}, 32'h1);

    // Writeback and kill together: busy clears.
    reg_wr = 1'b1; waddr = 5'd4; wdata = 32'h00000022; kill_load = 1'b1; kill_rd = 5'd4;
    #1;
    check("wb_kill_cycle", {31'b0, load_use_stall}, 32'h0);
    tick();
    reg_wr = 1'b0; kill_load = 1'b0;
    #1;
    check("wb_kill_clear", {31'b0, load_use_stall}, 32'h0);
    check("wb_kill_data", rdata1, 32'h00000022);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
